// File: rtl/comp_pkg.sv
// Shared comparator definitions: FSM states, result codes and size helpers.
package comp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } comp_state_e;

    typedef enum logic [1:0] {
        ResLt = 2'b00,
        ResEq = 2'b01,
        ResGt = 2'b10
    } comp_res_e;

    function automatic int unsigned calc_ndig(int unsigned width, int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned calc_sw(int unsigned ndig);
        return $clog2(ndig) + 1;
    endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational compare of one digit; invert_msb_i flips the top bit on both sides
// so a two's-complement MSB digit orders as offset binary.
module comp_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             invert_msb_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    logic [DIGIT-1:0] flip;
    logic [DIGIT-1:0] a_x;
    logic [DIGIT-1:0] b_x;

    always_comb begin
        flip            = '0;
        flip[DIGIT-1]   = invert_msb_i;
        a_x             = a_i ^ flip;
        b_x             = b_i ^ flip;
        lt_o            = a_x < b_x;
        eq_o            = a_x == b_x;
        gt_o            = a_x > b_x;
    end

endmodule

// File: rtl/seq_mag_comp.sv
// Digit-serial MSB-first magnitude comparator with early exit on the first unequal digit.
// Unsigned or two's-complement, behind a start/done handshake.
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  DIGIT = 4,
    localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT),
    localparam int unsigned SW    = calc_sw(NDIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [SW-1:0]    steps
);

    localparam int unsigned     PW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   PtrMax = PW'(NDIG - 1);

    comp_state_e      state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [PW-1:0]    ptr_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;
    logic             done_q;
    logic [SW-1:0]    steps_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             dig_lt;
    logic             dig_eq;
    logic             dig_gt;

    assign a_sh = a_q >> (ptr_q * DIGIT);
    assign b_sh = b_q >> (ptr_q * DIGIT);

    comp_digit #(
        .DIGIT (DIGIT)
    ) u_comp_digit (
        .a_i          (a_sh[DIGIT-1:0]),
        .b_i          (b_sh[DIGIT-1:0]),
        .invert_msb_i (signed_q && (ptr_q == PtrMax)),
        .lt_o         (dig_lt),
        .eq_o         (dig_eq),
        .gt_o         (dig_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            ptr_q    <= PtrMax;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            done_q   <= 1'b0;
            steps_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= signed_mode;
                        ptr_q    <= PtrMax;
                        lt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        gt_q     <= 1'b0;
                        steps_q  <= '0;
                        state_q  <= StCompare;
                    end
                end
                StCompare: begin
                    steps_q <= steps_q + SW'(1);
                    if (dig_gt) begin
                        gt_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (dig_lt) begin
                        lt_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (ptr_q == '0) begin
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        ptr_q <= ptr_q - PW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign lt    = lt_q;
    assign eq    = eq_q;
    assign gt    = gt_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp (WIDTH=16, DIGIT=4) with hand-computed expectations.
module tb_seq_mag_comp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [2:0]  steps;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt),
        .steps       (steps)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start edge E0; done must be seen just after edge E(exp_k). Optionally change a
    // after E0, or pulse start again so it is sampled at E2 (mid-compare).
    task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic sm, input bit chg, input logic [15:0] a_new,
                           input bit restart, input logic exp_lt, input logic exp_eq,
                           input logic exp_gt, input int exp_k);
        int  n;
        bit  got;
        int  extra;
        @(posedge clk); #1;
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1 && chg) a = a_new;
            if (n == 1 && restart) start = 1'b1;
            if (n == 2 && restart) start = 1'b0;
            if (done) got = 1;
            else check({tag, ".busy_run"}, 32'(busy), 32'd1);
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(n), 32'(exp_k));
        check({tag, ".lt"}, 32'(lt), 32'(exp_lt));
        check({tag, ".eq"}, 32'(eq), 32'(exp_eq));
        check({tag, ".gt"}, 32'(gt), 32'(exp_gt));
        check({tag, ".steps"}, 32'(steps), 32'(exp_k));
        check({tag, ".busy_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check({tag, ".hold_res"}, 32'({lt, eq, gt}), 32'({exp_lt, exp_eq, exp_gt}));
        check({tag, ".hold_steps"}, 32'(steps), 32'(exp_k));
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check({tag, ".no_extra_done"}, 32'(extra), 32'd0);
    endtask

    initial begin : stim
        int extra;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.res", 32'({lt, eq, gt}), 32'd0);
        check("reset.steps", 32'(steps), 32'd0);
        rst = 1'b0;

        run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, 0, 16'h0, 0, 1'b0, 1'b1, 1'b0, 4);
        run_cmp("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 0, 16'h0, 0, 1'b0, 1'b0, 1'b1, 1);
        run_cmp("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 1);
        run_cmp("u_12a4_12b4", 16'h12A4, 16'h12B4, 1'b0, 0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 3);
        run_cmp("u_isolate", 16'h12A4, 16'h12B4, 1'b0, 1, 16'hFFFF, 0, 1'b1, 1'b0, 1'b0, 3);
        run_cmp("s_fffe_ffff", 16'hFFFE, 16'hFFFF, 1'b1, 0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 4);
        run_cmp("s_0001_ffff", 16'h0001, 16'hFFFF, 1'b1, 0, 16'h0, 0, 1'b0, 1'b0, 1'b1, 1);
        run_cmp("restart_ign", 16'h1111, 16'h1112, 1'b0, 0, 16'h0, 1, 1'b1, 1'b0, 1'b0, 4);

        // Reset during the second COMPARE cycle discards the comparison.
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h1112; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.res", 32'({lt, eq, gt}), 32'd0);
        check("midrst.steps", 32'(steps), 32'd0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("midrst.no_done", 32'(extra), 32'd0);

        run_cmp("post_rst", 16'h0000, 16'h0001, 1'b0, 0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
